// File: rtl/cmult_arbiter.sv
// Two-requester round-robin front end for a pipelined complex multiplier, with a tag
// pipeline matching the multiplier latency. Optional grant statistics: CMULT_ARB_STAT_EN.
module cmult_arbiter #(
  parameter int DATA_RES = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic                sys_clk,
  input  logic                sys_nrst,
  input  logic                sys_en,
  input  logic                req0_valid,
  input  logic                req1_valid,
  output logic                req0_ready,
  output logic                req1_ready,
  input  logic [DATA_RES-1:0] req0_din_r,
  input  logic [DATA_RES-1:0] req0_din_i,
  input  logic [DATA_RES-1:0] req1_din_r,
  input  logic [DATA_RES-1:0] req1_din_i,
  input  logic [DATA_RES:0]   req0_tw_r,
  input  logic [DATA_RES:0]   req0_tw_i,
  input  logic [DATA_RES:0]   req1_tw_r,
  input  logic [DATA_RES:0]   req1_tw_i,
  output logic [DATA_RES-1:0] mult_din_r,
  output logic [DATA_RES-1:0] mult_din_i,
  output logic [DATA_RES:0]   mult_tw_r,
  output logic [DATA_RES:0]   mult_tw_i,
  input  logic [DATA_RES-1:0] mult_dout_r,
  input  logic [DATA_RES-1:0] mult_dout_i,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [DATA_RES-1:0] rsp_dout_r,
  output logic [DATA_RES-1:0] rsp_dout_i,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1
);

  logic last_gnt;
  logic grant_any;
  logic grant_id;

  // Grant is gated by reset so ready never asserts in a reset cycle.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (sys_nrst && sys_en) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~last_gnt;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any & ~grant_id;
  assign req1_ready = grant_any & grant_id;

  always_comb begin
    mult_din_r = req0_din_r;
    mult_din_i = req0_din_i;
    mult_tw_r  = req0_tw_r;
    mult_tw_i  = req0_tw_i;
    if (grant_any && grant_id) begin
      mult_din_r = req1_din_r;
      mult_din_i = req1_din_i;
      mult_tw_r  = req1_tw_r;
      mult_tw_i  = req1_tw_i;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      last_gnt <= 1'b1;
    end else if (grant_any) begin
      last_gnt <= grant_id;
    end
  end

  generate
    if (PIPE_LAT == 0) begin : g_tag_comb
      assign rsp_valid = grant_any;
      assign rsp_id    = grant_id;
    end else begin : g_tag_pipe
      logic [PIPE_LAT-1:0] tag_v;
      logic [PIPE_LAT-1:0] tag_id;

      always_ff @(posedge sys_clk) begin
        if (!sys_nrst) begin
          tag_v  <= '0;
          tag_id <= '0;
        end else if (sys_en) begin
          tag_v[0]  <= grant_any;
          tag_id[0] <= grant_id;
          for (int i = 1; i < PIPE_LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
          end
        end
      end

      // Masked during reset: the last stage still shows pre-reset contents until the edge.
      assign rsp_valid = tag_v[PIPE_LAT-1] & sys_nrst;
      assign rsp_id    = tag_id[PIPE_LAT-1];
    end
  endgenerate

  assign rsp_dout_r = mult_dout_r;
  assign rsp_dout_i = mult_dout_i;

`ifdef CMULT_ARB_STAT_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (req0_ready && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (req1_ready && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = 16'h0000;
  assign grant_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_cmult_arbiter.sv
// Bench for cmult_arbiter: directed scenarios plus random traffic against a queue-based
// reference model; includes a stand-in pipelined multiplier driven by sys_en.
module tb_cmult_arbiter;
  localparam int DR = 16;
  localparam int PL = 2;

  logic          sys_clk = 1'b0;
  logic          sys_nrst, sys_en, req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DR-1:0] req0_din_r, req0_din_i, req1_din_r, req1_din_i;
  logic [DR:0]   req0_tw_r, req0_tw_i, req1_tw_r, req1_tw_i;
  logic [DR-1:0] mult_din_r, mult_din_i;
  logic [DR:0]   mult_tw_r, mult_tw_i;
  logic [DR-1:0] mult_dout_r, mult_dout_i;
  logic          rsp_valid, rsp_id;
  logic [DR-1:0] rsp_dout_r, rsp_dout_i;
  logic [15:0]   grant_cnt0, grant_cnt1;

  always #5 sys_clk = ~sys_clk;

  cmult_arbiter #(.DATA_RES(DR), .PIPE_LAT(PL)) dut (
    .sys_clk(sys_clk), .sys_nrst(sys_nrst), .sys_en(sys_en),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_din_r(req0_din_r), .req0_din_i(req0_din_i),
    .req1_din_r(req1_din_r), .req1_din_i(req1_din_i),
    .req0_tw_r(req0_tw_r), .req0_tw_i(req0_tw_i),
    .req1_tw_r(req1_tw_r), .req1_tw_i(req1_tw_i),
    .mult_din_r(mult_din_r), .mult_din_i(mult_din_i),
    .mult_tw_r(mult_tw_r), .mult_tw_i(mult_tw_i),
    .mult_dout_r(mult_dout_r), .mult_dout_i(mult_dout_i),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_dout_r(rsp_dout_r), .rsp_dout_i(rsp_dout_i),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // Stand-in multiplier: an arbitrary but operand-sensitive function, PL stages, stalled by sys_en.
  function automatic logic [DR-1:0] f_r(input logic [DR-1:0] d, input logic [DR:0] t);
    return d + t[DR-1:0];
  endfunction
  function automatic logic [DR-1:0] f_i(input logic [DR-1:0] d, input logic [DR:0] t);
    return d ^ t[DR:1];
  endfunction

  logic [DR-1:0] mp_r [PL];
  logic [DR-1:0] mp_i [PL];
  always @(posedge sys_clk) begin
    if (sys_en) begin
      mp_r[0] <= f_r(mult_din_r, mult_tw_r);
      mp_i[0] <= f_i(mult_din_i, mult_tw_i);
      for (int i = 1; i < PL; i++) begin
        mp_r[i] <= mp_r[i-1];
        mp_i[i] <= mp_i[i-1];
      end
    end
  end
  assign mult_dout_r = mp_r[PL-1];
  assign mult_dout_i = mp_i[PL-1];

  // Reference model: expected responses keyed by the enabled-cycle count at which they show up.
  typedef struct {
    int            due;
    logic          id;
    logic [DR-1:0] dr;
    logic [DR-1:0] di;
  } exp_t;
  exp_t  q[$];
  int    ecnt = 0;
  logic  m_last = 1'b1;
  int    m_cnt0 = 0;
  int    m_cnt1 = 0;
  int    d0_force = -1;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v0, input logic v1, input logic en, input logic nrst);
    logic          g_any, g_id, exp_v;
    logic [DR-1:0] sel_dr, sel_di;
    logic [DR:0]   sel_tr, sel_ti;
    exp_t          e;
    @(negedge sys_clk);
    sys_nrst   = nrst;
    sys_en     = en;
    req0_valid = v0;
    req1_valid = v1;
    req0_din_r = (d0_force >= 0) ? d0_force[DR-1:0] : DR'($urandom);
    req0_din_i = DR'($urandom);
    req1_din_r = DR'($urandom);
    req1_din_i = DR'($urandom);
    req0_tw_r  = (DR+1)'($urandom);
    req0_tw_i  = (DR+1)'($urandom);
    req1_tw_r  = (DR+1)'($urandom);
    req1_tw_i  = (DR+1)'($urandom);
    #1;
    g_any = nrst && en && (v0 || v1);
    g_id  = (v0 && v1) ? !m_last : v1;
    chk("req0_ready", 32'(req0_ready), 32'(g_any && !g_id));
    chk("req1_ready", 32'(req1_ready), 32'(g_any && g_id));
    if (g_any) begin
      sel_dr = g_id ? req1_din_r : req0_din_r;
      sel_di = g_id ? req1_din_i : req0_din_i;
      sel_tr = g_id ? req1_tw_r : req0_tw_r;
      sel_ti = g_id ? req1_tw_i : req0_tw_i;
      chk("mult_din_r", 32'(mult_din_r), 32'(sel_dr));
      chk("mult_tw_i", 32'(mult_tw_i), 32'(sel_ti));
      e.due = ecnt + PL;
      e.id  = g_id;
      e.dr  = f_r(sel_dr, sel_tr);
      e.di  = f_i(sel_di, sel_ti);
      q.push_back(e);
    end
    while (q.size() > 0 && q[0].due < ecnt) void'(q.pop_front());
    exp_v = nrst && q.size() > 0 && q[0].due == ecnt;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_dout_r", 32'(rsp_dout_r), 32'(q[0].dr));
      chk("rsp_dout_i", 32'(rsp_dout_i), 32'(q[0].di));
    end
`ifdef CMULT_ARB_STAT_EN
    chk("grant_cnt0", 32'(grant_cnt0), m_cnt0);
    chk("grant_cnt1", 32'(grant_cnt1), m_cnt1);
`else
    chk("grant_cnt0", 32'(grant_cnt0), 0);
    chk("grant_cnt1", 32'(grant_cnt1), 0);
`endif
    @(posedge sys_clk);
    if (!nrst) begin
      q.delete();
      m_last = 1'b1;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else if (en) begin
      ecnt++;
      if (g_any) begin
        m_last = g_id;
        if (!g_id && m_cnt0 < 65535) m_cnt0++;
        if (g_id && m_cnt1 < 65535) m_cnt1++;
      end
    end
  endtask

  initial begin
    sys_nrst = 1'b0; sys_en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_din_r = '0; req0_din_i = '0; req1_din_r = '0; req1_din_i = '0;
    req0_tw_r = '0; req0_tw_i = '0; req1_tw_r = '0; req1_tw_i = '0;

    // reset, including requests and enable asserted while in reset
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);

    // req0 alone for four cycles with known samples, then drain
    for (int k = 0; k < 4; k++) begin
      d0_force = 100 + k;
      step(1, 0, 1, 1);
    end
    d0_force = -1;
    repeat (3) step(0, 0, 1, 1);

    // continuous contention right after reset: strict alternation starting with req0
    step(0, 0, 1, 0);
    repeat (6) step(1, 1, 1, 1);
    repeat (3) step(0, 0, 1, 1);
`ifdef CMULT_ARB_STAT_EN
    chk("cnt0_after_alt", 32'(grant_cnt0), 3);
    chk("cnt1_after_alt", 32'(grant_cnt1), 3);
`endif

    // single grant then a five-cycle stall with requests pending
    step(0, 1, 1, 1);
    repeat (5) step(1, 1, 0, 1);
    repeat (4) step(0, 0, 1, 1);

    // two grants in flight, then reset: nothing emerges, next contention goes to req0
    step(1, 0, 1, 1);
    step(0, 1, 1, 1);
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 1, 1);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    repeat (3) step(0, 0, 1, 1);

    // random traffic with stalls and occasional resets
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom), 1'($urandom), ($urandom_range(99) < 75), ($urandom_range(99) >= 3));
    end

`ifdef CMULT_ARB_STAT_EN
    // saturation of the req0 grant counter
    step(0, 0, 1, 0);
    for (int k = 0; k < 65537; k++) step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("cnt0_saturated", 32'(grant_cnt0), 32'h0000_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cmult_arbiter.md
CMULT_ARBITER -- requirements
Module: cmult_arbiter

Interface
REQ-001 Parameter DATA_RES, default 16: sample width per real/imag component; twiddle components are DATA_RES+1 bits.
REQ-002 Parameter PIPE_LAT, default 2: register latency of the attached complex multiplier; legal values 0..3.
REQ-003 sys_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 sys_nrst  in  1  reset, synchronous, active-low.
REQ-005 sys_en  in  1  global advance; when low, all state holds, and the same signal drives the multiplier's enable.
REQ-006 req0_valid / req1_valid  in  1 each  requester N presents an operand pair.
REQ-007 req0_ready / req1_ready  out  1 each  requester N's operand is accepted this cycle.
REQ-008 req0_din_r, req0_din_i, req1_din_r, req1_din_i  in  DATA_RES each  sample operands.
REQ-009 req0_tw_r, req0_tw_i, req1_tw_r, req1_tw_i  in  DATA_RES+1 each  twiddle operands.
REQ-010 mult_din_r, mult_din_i  out  DATA_RES each  muxed sample to the multiplier.
REQ-011 mult_tw_r, mult_tw_i  out  DATA_RES+1 each  muxed twiddle to the multiplier.
REQ-012 mult_dout_r, mult_dout_i  in  DATA_RES each  multiplier result.
REQ-013 rsp_valid  out  1  rsp_dout carries a result this cycle.
REQ-014 rsp_id  out  1  requester that owns the result.
REQ-015 rsp_dout_r, rsp_dout_i  out  DATA_RES each  result, equal to mult_dout.
REQ-016 grant_cnt0, grant_cnt1  out  16 each  grant statistics (see REQ-031).

Function
REQ-017 Grant: the arbiter issues at most one grant per cycle, and only when sys_en=1; reqN_ready=1 exactly when requester N is granted.
REQ-018 Both valid: round-robin; the requester not granted last wins; last-grant register resets to 1 so req0 wins the first contention.
REQ-019 Single valid: that requester is granted; the last-grant register updates on every grant.
REQ-020 No valid or sys_en=0: no grant, ready outputs 0, and the last-grant register holds.
REQ-021 Operand mux: mult_din/mult_tw are driven combinationally from the granted requester; with no grant they are driven from req0 (don't-care for correctness).
REQ-022 Tag pipeline: a {valid,id} shift register PIPE_LAT deep, advanced only when sys_en=1; stage 0 loads {grant_any, grant_id}.
REQ-023 rsp_valid/rsp_id come from the last tag stage; for PIPE_LAT=0 they equal the current-cycle grant combinationally.
REQ-024 Latency: the result for an operand accepted in cycle T appears at T+PIPE_LAT counting only sys_en=1 cycles; sys_en low stalls tag and multiplier together.
REQ-025 Back-to-back: the block sustains one grant per enabled cycle; alternating grants under continuous dual request produce an exact alternation of rsp_id.
REQ-026 Requesters may drop valid without handshake; the arbiter keeps no pending state per requester.

Reset
REQ-027 sys_nrst=0 at a clock edge clears all tag stages to invalid, sets last-grant to 1, and clears the grant counters, regardless of sys_en.
REQ-028 During reset, reqN_ready=0 and rsp_valid=0; mult_* outputs are don't-care.
REQ-029 Reset mid-operation discards in-flight results: no rsp_valid is issued for operands accepted before reset.
REQ-030 First grant is possible in the first cycle with sys_nrst=1.

Configuration
REQ-031 Macro CMULT_ARB_STAT_EN defined: grant_cnt0/grant_cnt1 increment on each grant to requester 0/1, saturate at 16'hFFFF, and clear on reset.
REQ-032 Macro CMULT_ARB_STAT_EN undefined: no counter registers exist and grant_cnt0/grant_cnt1 are tied to 0.

Verification
REQ-033 PIPE_LAT=2; req0 only, valid for 4 enabled cycles with din_r=100,101,102,103 -> four rsp_valid with rsp_id=0, each exactly 2 cycles after its req0_ready.
REQ-034 Both valid continuously for 6 cycles after reset -> grant order 0,1,0,1,0,1; rsp_id follows the same order; grant_cnt0=grant_cnt1=3 with STAT_EN.
REQ-035 PIPE_LAT=3; one grant, then sys_en=0 for 5 cycles, then 1 -> rsp_valid asserts only after 3 enabled edges; no ready during stall.
REQ-036 PIPE_LAT=2; grants in 2 consecutive cycles, then sys_nrst=0 for 1 cycle -> no rsp_valid ever; next contention granted to req0.
REQ-037 PIPE_LAT=0; req1 valid with din_r=16'h7FFF -> req1_ready, rsp_valid, and rsp_id=1 in the same cycle; rsp_dout equals mult_dout.
REQ-038 STAT_EN; force 65 537 grants to req0 -> grant_cnt0 holds 16'hFFFF.
